mul_pipe_unit: RTL

//  Parametrised, fully pipelined RV32M/RV64M multiply unit with valid/ready backpressure and pipeline flush.

---
 rtl/exu_pkg.sv | 37 +++
 rtl/mul_pipe_slice.sv | 51 +++++
 rtl/mul_pipe_unit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/exu_pkg.sv
`default_nettype none
// ============================================================================
// Package  : exu_pkg
// Brief    : Shared definitions for the execute-cluster multiply unit:
//            RV32M/RV64M multiply op encodings (funct3[1:0]), the operand
//            sign-select attributes and the helpers that derive them.
// Revision : 1.0 - initial release
// ============================================================================
package exu_pkg;

  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  // Signedness of each operand for one multiply op.
  typedef struct packed {
    logic rs1_signed;
    logic rs2_signed;
  } mul_sign_t;

  // rs1 is signed for MULH/MULHSU, rs2 only for MULH. MUL's low half does not
  // depend on signedness, so it uses the unsigned path.
  function automatic mul_sign_t mul_sign_sel(input logic [1:0] op);
    mul_sign_t s;
    s.rs1_signed = (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
    s.rs2_signed = (op == MUL_OP_MULH);
    return s;
  endfunction

  // Every op except MUL returns the upper half of the product.
  function automatic logic mul_takes_high(input logic [1:0] op);
    return op != MUL_OP_MUL;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_pipe_slice.sv
`default_nettype none
// ============================================================================
// Module   : mul_pipe_slice
// Brief    : One pipeline stage: a valid bit plus a payload register of any
//            packed type. Loads when i_load is high, holds otherwise; flush
//            clears the valid bit only; reset clears valid and payload.
// Ports    : clk, rstn (sync, active-low), i_flush, i_load,
//            i_valid/i_data (from the previous stage),
//            o_valid/o_data (registered stage contents)
// Revision : 1.0 - initial release
// ============================================================================
module mul_pipe_slice
  import exu_pkg::*;
#(
  parameter type PAYLOAD_T = logic
) (
  input  logic     clk,
  input  logic     rstn,
  input  logic     i_flush,
  input  logic     i_load,
  input  logic     i_valid,
  input  PAYLOAD_T i_data,
  output logic     o_valid,
  output PAYLOAD_T o_data
);

  logic     r_valid;
  PAYLOAD_T r_data;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (i_flush) begin
        r_valid <= 1'b0;
      end else if (i_load) begin
        r_valid <= i_valid;
      end
      // Payload is left untouched on flush; it is dead once valid drops.
      if (i_load && !i_flush) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/mul_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_pipe_unit
// Brief    : Fully pipelined RV32M/RV64M multiply unit (MUL/MULH/MULHSU/MULHU)
//            with valid/ready backpressure, bubble squeezing and flush.
//            rd, ROB tag and PC+4 travel with each op. Latency = STAGES.
// Ports    : clk, rstn (sync, active-low), flush
//            in_valid/in_ready, in_op, in_rs1, in_rs2, in_rd, in_rob, in_pc4
//            out_valid/out_ready, out_result, out_rd, out_rob, out_pc4
//            busy (any stage holds a valid op)
// Revision : 1.0 - initial release
// ============================================================================
module mul_pipe_unit
  import exu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 3,
  parameter int RD_W   = 5,
  parameter int ROB_W  = 7
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [RD_W-1:0]  in_rd,
  input  logic [ROB_W-1:0] in_rob,
  input  logic [XLEN-1:0]  in_pc4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [RD_W-1:0]  out_rd,
  output logic [ROB_W-1:0] out_rob,
  output logic [XLEN-1:0]  out_pc4,
  output logic             busy
);

  // Payload layouts depend on the module parameters, so they live here.
  // Stage 0 carries the extended operands; later stages carry the product.
  typedef struct packed {
    logic [1:0]       op;
    logic [XLEN:0]    opa;
    logic [XLEN:0]    opb;
    logic [RD_W-1:0]  rd;
    logic [ROB_W-1:0] rob;
    logic [XLEN-1:0]  pc4;
  } s0_payload_t;

  typedef struct packed {
    logic [1:0]        op;
    logic [2*XLEN-1:0] prod;
    logic [RD_W-1:0]   rd;
    logic [ROB_W-1:0]  rob;
    logic [XLEN-1:0]   pc4;
  } sk_payload_t;

  logic [STAGES-1:0]        w_v;
  logic [STAGES-1:0]        w_adv;
  mul_sign_t                w_sign;
  s0_payload_t              w_s0_d;
  s0_payload_t              w_s0_q;
  sk_payload_t              w_s1_d;
  sk_payload_t              w_sk_q [1:STAGES-1];
  sk_payload_t              w_last;
  logic signed [2*XLEN-1:0] w_mul_a;
  logic signed [2*XLEN-1:0] w_mul_b;

  // A stage may load when it is empty or when the stage after it moves.
  // Built in one process so the chain is a simple ripple from the output.
  always_comb begin
    w_adv = '0;
    w_adv[STAGES-1] = ~w_v[STAGES-1] | out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      w_adv[k] = ~w_v[k] | w_adv[k+1];
    end
  end

  // Operand extension to XLEN+1 bits in front of stage 0.
  assign w_sign = mul_sign_sel(in_op);

  always_comb begin
    w_s0_d     = '0;
    w_s0_d.op  = in_op;
    w_s0_d.opa = {w_sign.rs1_signed & in_rs1[XLEN-1], in_rs1};
    w_s0_d.opb = {w_sign.rs2_signed & in_rs2[XLEN-1], in_rs2};
    w_s0_d.rd  = in_rd;
    w_s0_d.rob = in_rob;
    w_s0_d.pc4 = in_pc4;
  end

  // Signed (XLEN+1)x(XLEN+1) multiply between stage 0 and stage 1. Operands
  // are sign-extended to the product width; modular arithmetic at 2*XLEN bits
  // yields exactly the low 2*XLEN bits of the full product.
  assign w_mul_a = {{(XLEN-1){w_s0_q.opa[XLEN]}}, w_s0_q.opa};
  assign w_mul_b = {{(XLEN-1){w_s0_q.opb[XLEN]}}, w_s0_q.opb};

  always_comb begin
    w_s1_d      = '0;
    w_s1_d.op   = w_s0_q.op;
    w_s1_d.prod = w_mul_a * w_mul_b;
    w_s1_d.rd   = w_s0_q.rd;
    w_s1_d.rob  = w_s0_q.rob;
    w_s1_d.pc4  = w_s0_q.pc4;
  end

  // Stage chain. Stages after the multiplier are plain registers so
  // synthesis retiming can spread the multiply across them.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_in
      mul_pipe_slice #(.PAYLOAD_T(s0_payload_t)) u_slice (
        .clk     (clk),
        .rstn    (rstn),
        .i_flush (flush),
        .i_load  (w_adv[0]),
        .i_valid (in_valid),
        .i_data  (w_s0_d),
        .o_valid (w_v[0]),
        .o_data  (w_s0_q)
      );
    end else if (k == 1) begin : g_mul
      mul_pipe_slice #(.PAYLOAD_T(sk_payload_t)) u_slice (
        .clk     (clk),
        .rstn    (rstn),
        .i_flush (flush),
        .i_load  (w_adv[1]),
        .i_valid (w_v[0]),
        .i_data  (w_s1_d),
        .o_valid (w_v[1]),
        .o_data  (w_sk_q[1])
      );
    end else begin : g_carry
      mul_pipe_slice #(.PAYLOAD_T(sk_payload_t)) u_slice (
        .clk     (clk),
        .rstn    (rstn),
        .i_flush (flush),
        .i_load  (w_adv[k]),
        .i_valid (w_v[k-1]),
        .i_data  (w_sk_q[k-1]),
        .o_valid (w_v[k]),
        .o_data  (w_sk_q[k])
      );
    end
  end

  assign w_last = w_sk_q[STAGES-1];

  // Flush blocks both the accept and the delivery in the same cycle.
  assign in_ready   = w_adv[0] & ~flush;
  assign out_valid  = w_v[STAGES-1] & ~flush;
  assign out_result = mul_takes_high(w_last.op) ? w_last.prod[2*XLEN-1:XLEN]
                                                : w_last.prod[XLEN-1:0];
  assign out_rd     = w_last.rd;
  assign out_rob    = w_last.rob;
  assign out_pc4    = w_last.pc4;
  assign busy       = |w_v;

endmodule
`default_nettype wire
